// File: rtl/enoc_alloc_pkg.sv
// enoc_alloc_pkg
// Shared definitions for the ENoC switch allocator:
//   alloc_state_e  - per-output allocation state (IDLE / LOCKED)
//   alloc_idx_w    - width of a port index for an M-port router
//   alloc_mod_inc  - modular increment (v+1) mod m with explicit wrap,
//                    valid for any m, not only powers of two
// Configuration: ENOC_ALLOC_LOCK_EN (used by enoc_switch_allocator).
package enoc_alloc_pkg;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_LOCKED = 1'b1
  } alloc_state_e;

  function automatic int unsigned alloc_idx_w(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int unsigned alloc_mod_inc(input int unsigned v, input int unsigned m);
    return (v + 1 >= m) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/enoc_rr_arbiter.sv
// enoc_rr_arbiter
// Combinational M-way rotating-priority arbiter. The first requester found
// scanning ptr, ptr+1, ... (wrapping mod M) wins.
// Ports:
//   ptr  in  [W-1:0]  priority pointer (must be < M)
//   req  in  [0:M-1]  request per input
//   gnt  out [0:M-1]  one-hot grant
//   idx  out [W-1:0]  winning input index (0 when none)
//   any  out          at least one request present
module enoc_rr_arbiter import enoc_alloc_pkg::*; #(
  parameter int unsigned M = 5,
  localparam int unsigned W = alloc_idx_w(M)
) (
  input  logic [W-1:0] ptr,
  input  logic [0:M-1] req,
  output logic [0:M-1] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  // One extra bit so ptr+k cannot overflow before the wrap subtraction.
  logic [W:0]   sum;
  logic [W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int k = 0; k < int'(M); k++) begin
      sum = {1'b0, ptr} + (W+1)'(k);
      if (sum >= (W+1)'(M)) begin
        sum = sum - (W+1)'(M);
      end
      cand = sum[W-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enoc_switch_allocator.sv
// enoc_switch_allocator
// Per-output wormhole switch allocator. Each output arbitrates among the
// inputs requesting it with round-robin priority and, when wormhole locking
// is compiled in, stays locked to the winning input until its tail flit is
// granted. Grants are combinational (zero-cycle latency).
// Ports:
//   clk        in                 clock
//   reset      in                 synchronous active-high reset
//   i_req      in  [0:M-1][0:M-1] one-hot output request per input
//   i_tail     in  [0:M-1]        head-of-queue flit is a tail
//   i_en       in  [0:M-1]        output can accept a flit
//   o_grant    out [0:M-1][0:M-1] o_grant[i][o]: input i -> output o
//   o_pop      out [0:M-1]        input dequeues a flit
//   o_sel      out [0:M-1][W-1:0] crossbar select per output
//   o_sel_val  out [0:M-1]        output carries a flit
// Configuration: define ENOC_ALLOC_LOCK_EN for wormhole locking; without it
// every flit is arbitrated independently and i_tail is ignored.
module enoc_switch_allocator import enoc_alloc_pkg::*; #(
  parameter int unsigned M = 5,
  localparam int unsigned W = alloc_idx_w(M)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:M-1][0:M-1]   i_req,
  input  logic [0:M-1]          i_tail,
  input  logic [0:M-1]          i_en,
  output logic [0:M-1][0:M-1]   o_grant,
  output logic [0:M-1]          o_pop,
  output logic [0:M-1][W-1:0]   o_sel,
  output logic [0:M-1]          o_sel_val
);

  // A malformed request keeps only its lowest-index set port, so an input
  // can never win two outputs in one cycle. req_col is the transpose:
  // req_col[o][i] = input i requests output o.
  logic [0:M-1][0:M-1] req_clean;
  logic [0:M-1][0:M-1] req_col;
  logic [0:M-1]        req_taken;

  always_comb begin
    req_clean = '0;
    req_col   = '0;
    req_taken = '0;
    for (int i = 0; i < int'(M); i++) begin
      for (int o = 0; o < int'(M); o++) begin
        if (!req_taken[i] && i_req[i][o]) begin
          req_taken[i]    = 1'b1;
          req_clean[i][o] = 1'b1;
        end
        req_col[o][i] = req_clean[i][o];
      end
    end
  end

  logic [0:M-1]        out_val;
  logic [0:M-1][W-1:0] out_idx;

  for (genvar gi = 0; gi < M; gi++) begin : g_out
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] win_idx;
    logic         win_any;
    logic [0:M-1] unused_onehot;
    logic         val;
    logic [W-1:0] idx;

    enoc_rr_arbiter #(.M(M)) u_arb (
      .ptr (ptr_q),
      .req (req_col[gi]),
      .gnt (unused_onehot),
      .idx (win_idx),
      .any (win_any)
    );

`ifdef ENOC_ALLOC_LOCK_EN
    alloc_state_e state_q, state_d;
    logic [W-1:0] owner_q, owner_d;

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      val     = 1'b0;
      idx     = '0;
      if (state_q == ALLOC_IDLE) begin
        if (i_en[gi] && win_any) begin
          val   = 1'b1;
          idx   = win_idx;
          // Priority rotates only at packet start.
          ptr_d = W'(alloc_mod_inc(32'(win_idx), M));
          if (!i_tail[win_idx]) begin
            state_d = ALLOC_LOCKED;
            owner_d = win_idx;
          end
        end
      end else if (i_en[gi] && req_col[gi][owner_q]) begin
        // Locked: only the owner may move; bubbles and stalls just wait.
        val = 1'b1;
        idx = owner_q;
        if (i_tail[owner_q]) begin
          state_d = ALLOC_IDLE;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ALLOC_IDLE;
        owner_q <= '0;
        ptr_q   <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
      end
    end
`else
    always_comb begin
      ptr_d = ptr_q;
      val   = 1'b0;
      idx   = '0;
      if (i_en[gi] && win_any) begin
        val   = 1'b1;
        idx   = win_idx;
        ptr_d = W'(alloc_mod_inc(32'(win_idx), M));
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= ptr_d;
      end
    end
`endif

    assign out_val[gi] = val;
    assign out_idx[gi] = idx;
  end

`ifndef ENOC_ALLOC_LOCK_EN
  logic unused_tail;
  assign unused_tail = ^i_tail;
`endif

  // Fan grants out to the crossbar and input buffers; all quiet in reset.
  always_comb begin
    o_grant   = '0;
    o_pop     = '0;
    o_sel     = '0;
    o_sel_val = '0;
    if (!reset) begin
      for (int o = 0; o < int'(M); o++) begin
        if (out_val[o]) begin
          o_sel_val[o]             = 1'b1;
          o_sel[o]                 = out_idx[o];
          o_grant[out_idx[o]][o]   = 1'b1;
          o_pop[out_idx[o]]        = 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/enoc_switch_allocator.md
# enoc_switch_allocator

Per-output wormhole switch allocator for the ENoC router. Takes the one-hot output-port requests produced by each input port's route calculator and grants each output to at most one input with rotating (round-robin) priority. It then holds the grant until the packet's tail flit has passed. Its grants drive the crossbar selects and the input-buffer pops, so it sits between the route calculators/input FIFOs and the crossbar.

## Interface
- `M`, default 5: router port count (5 = 2D c,n,e,s,w; 7 = 3D); requests use the same port order as the route calculator, port 0 leftmost (`[0:M-1]`).
- `clk` input, 1 bit: single clock.
- `reset` input, 1 bit: reset, synchronous, active-high.
- `i_req` input, `[0:M-1][0:M-1]`: `i_req[i]` is the one-hot output request of input `i`'s head-of-queue flit (already valid-qualified); held for every flit of the packet.
- `i_tail` input, `[0:M-1]`: head-of-queue flit of input `i` is a tail flit (head=tail for single-flit packets).
- `i_en` input, `[0:M-1]`: output `o` can accept a flit this cycle (downstream credit/ready).
- `o_grant` output, `[0:M-1][0:M-1]`: `o_grant[i][o]` means the flit moves from input `i` to output `o` this cycle.
- `o_pop` output, `[0:M-1]`: input `i` dequeues a flit this cycle (OR of `o_grant[i]`).
- `o_sel` output, `[0:M-1][$clog2(M)-1:0]`: crossbar select (winning input index) per output.
- `o_sel_val` output, `[0:M-1]`: output `o` carries a flit this cycle.

## Operation
- Each output `o` has three items of state:
  - `state[o]`, either IDLE or LOCKED;
  - `owner[o]`, `$clog2(M)` bits;
  - `ptr[o]`, the `$clog2(M)`-bit round-robin priority pointer.
- IDLE, when `i_en[o]=1` and at least one `i_req[i][o]=1`:
  - The winner is the first requester scanning `ptr[o]`, `ptr[o]+1`, … and wrapping mod M.
  - Grant that winner this cycle.
  - Next `ptr[o]` = (winner+1) mod M, computed with explicit wrap; M need not be a power of 2.
  - If the granted flit is not a tail: LOCKED, with `owner[o]` = winner.
  - If it is a tail (single-flit packet): stay IDLE.
- LOCKED:
  - Grant only `owner[o]`, and only when `i_req[owner][o]=1` and `i_en[o]=1`. All other requesters are ignored.
  - A granted tail flit returns the output to IDLE.
  - If the owner's request drops (bubble) or `i_en[o]=0`: no grant, state held, ptr held.
- `ptr` changes only on an IDLE-state win (packet start), never mid-packet.
- `i_en[o]=0` in IDLE: no grant, all state held.
- Malformed `i_req[i]` (more than one bit set) is treated as a request for the lowest-index set port only. The bench also flags it as an assertion failure.
- Each input requests one output, so `o_pop` never reflects more than one grant per input.
- Reset:
  - State: all outputs IDLE, `owner=0`, `ptr=0`.
  - `o_grant`, `o_pop`, `o_sel_val` are forced to 0 and `o_sel` to 0 while `reset=1`.
- Reset mid-packet: lock and priority are discarded. Flushing the FIFOs is the input unit's responsibility.

## Timing
- Grant path is combinational from `i_req`/`i_tail`/`i_en` and registered state: zero-cycle grant latency.
- State, owner and ptr update on the `clk` edge ending the grant cycle.
- Throughput is one flit per output per cycle; a locked packet of N flits with no bubbles occupies exactly N consecutive cycles.
- A new packet can win an output in the cycle immediately after the previous tail is granted.
- The critical path is the M-way rotating-priority scan plus the grant-to-`o_pop` OR.

## Configuration
- `ENOC_ALLOC_LOCK_EN` defined: wormhole locking as above.
- `ENOC_ALLOC_LOCK_EN` undefined:
  - No LOCKED state; `i_tail` is ignored.
  - Every flit is arbitrated independently and `ptr` advances on every grant.
  - Intended for single-flit-packet configurations only.

## Structure
- Shared package `enoc_alloc_pkg`:
  - the alloc state enum (IDLE, LOCKED);
  - an index-width function `$clog2(M)`;
  - the modular increment helper.
- One sub-module, `enoc_rr_arbiter`:
  - M-way rotating-priority arbiter with `ptr` input, one-hot grant out and winner index out;
  - instantiated M times, one per output.

## Test plan
All scenarios use M=5.
- Single flit: after reset, `i_req[1]=5'b00100`, `i_tail[1]=1`, `i_en` all 1 → same-cycle `o_grant[1][2]=1`, `o_sel[2]=1`, `o_pop[1]=1`; next cycle `ptr[2]=2`, output 2 IDLE.
- Lock: inputs 0 and 3 each send 3-flit packets to output 4 (`5'b00001`) from `ptr=0` → input 0 is granted 3 consecutive cycles, then input 3 is granted 3 cycles; `ptr[4]` goes 1 then 4.
- Bubble: input 0 locked to output 4 drops `i_req` for 2 cycles while input 3 requests → no grant on output 4 in those cycles; input 0 resumes and finishes.
- Backpressure: `i_en[4]=0` for 3 cycles mid-packet → no grants, `o_sel_val[4]=0`, lock held; the packet completes after `i_en` returns.
- Wrap and reset: `ptr[0]=4`, inputs 0 and 4 request output 0 → input 4 wins; `reset` asserted mid-packet → outputs 0 that cycle, next cycle IDLE with `ptr=0`.
- Macro off: inputs 1 and 2 each present 2 flits to output 3 → grants alternate 1,2,1,2.
